// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier with a busy/done handshake.
// Retires two multiplier bits per cycle. Signed or unsigned operation is chosen
// per request. The result is exact in the low 2*WIDTH bits.
module booth_r4_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clkSys,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int ITER = WIDTH / 2 + 1;   // one Booth step per retired bit pair
    localparam int EW   = WIDTH + 2;       // extended operand width
    localparam int AW   = WIDTH + 3;       // accumulator width (room for +/-2A)
    localparam int CW   = $clog2(ITER);

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("booth_r4_multiplier: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CW-1:0]       cnt_r;
    logic [EW-1:0]       mcand_r;    // extended multiplicand
    logic [EW-1:0]       mplr_r;     // multiplier, refilled from the top with product bits
    logic                prev_r;     // b[2i-1] of the current triplet
    logic [AW-1:0]       acc_r;
    logic                busy_r;
    logic                done_r;
    logic [2*WIDTH-1:0]  product_r;

    logic                accept_s;
    logic                last_s;
    logic [EW-1:0]       a_ext_s;
    logic [EW-1:0]       b_ext_s;
    logic [AW-1:0]       one_a_s;
    logic [AW-1:0]       two_a_s;
    logic [AW-1:0]       pp_s;
    logic [AW-1:0]       sum_s;

    // Request acceptance, last-step detection and operand extension.
    always_comb begin
        accept_s = 1'b0;
        if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        last_s = (state_r == ST_CALC) && (cnt_r == CW'(ITER - 1));
        if (signed_mode) begin
            a_ext_s = {{2{a[WIDTH-1]}}, a};
            b_ext_s = {{2{b[WIDTH-1]}}, b};
        end else begin
            a_ext_s = {2'b00, a};
            b_ext_s = {2'b00, b};
        end
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_CALC;
                else       state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_CALC;
            end
            ST_DONE: begin
                if (start) state_s = ST_CALC;
                else       state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Booth recoding of the current triplet into a partial product, then accumulate.
    always_comb begin
        one_a_s = {mcand_r[EW-1], mcand_r};
        two_a_s = {mcand_r, 1'b0};
        case ({mplr_r[1:0], prev_r})
            3'b001, 3'b010: pp_s = one_a_s;
            3'b011:         pp_s = two_a_s;
            3'b100:         pp_s = {AW{1'b0}} - two_a_s;
            3'b101, 3'b110: pp_s = {AW{1'b0}} - one_a_s;
            default:        pp_s = {AW{1'b0}};
        endcase
        sum_s = acc_r + pp_s;
    end

    // FSM state register.
    always_ff @(posedge clkSys or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Datapath: load on accept, one add-and-shift per CALC cycle, capture result on the last step.
    always_ff @(posedge clkSys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            mcand_r   <= {EW{1'b0}};
            mplr_r    <= {EW{1'b0}};
            prev_r    <= 1'b0;
            acc_r     <= {AW{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            mcand_r <= a_ext_s;
            mplr_r  <= b_ext_s;
            prev_r  <= 1'b0;
            acc_r   <= {AW{1'b0}};
        end else if (state_r == ST_CALC) begin
            cnt_r  <= cnt_r + CW'(1);
            acc_r  <= {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
            mplr_r <= {sum_s[1:0], mplr_r[EW-1:2]};
            prev_r <= mplr_r[1];
            if (last_s) begin
                // Low 2*WIDTH bits of {shifted acc, shifted multiplier register}.
                product_r <= {sum_s[WIDTH-1:0], mplr_r[EW-1:2]};
            end else begin
                product_r <= product_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Handshake flags: busy across CALC, done as a one-cycle pulse into DONE.
    always_ff @(posedge clkSys or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
            if (accept_s)    busy_r <= 1'b1;
            else if (last_s) busy_r <= 1'b0;
            else             busy_r <= busy_r;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench: a 32-bit and an 8-bit instance are checked against
// plain integer multiplication, with directed corners, handshake and reset cases.
module tb_booth_r4_multiplier;

    logic        clkSys = 1'b0;
    logic        rst_n  = 1'b0;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = 32'd0, b32 = 32'd0;
    logic        busy32, done32;
    logic [63:0] prod32;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        busy8, done8;
    logic [15:0] prod8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clkSys = ~clkSys;

    booth_r4_multiplier #(.WIDTH(32)) u_dut32 (
        .clkSys(clkSys), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
        .a(a32), .b(b32), .busy(busy32), .product(prod32), .done(done32));

    booth_r4_multiplier #(.WIDTH(8)) u_dut8 (
        .clkSys(clkSys), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .product(prod8), .done(done8));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference: exact integer product truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input bit w8, input bit sm, input logic [31:0] a, input logic [31:0] b);
        longint x;
        if (w8) begin
            if (sm) x = longint'($signed(a[7:0])) * longint'($signed(b[7:0]));
            else    x = longint'(a[7:0]) * longint'(b[7:0]);
            return {48'd0, x[15:0]};
        end
        if (sm) x = longint'($signed(a)) * longint'($signed(b));
        else    x = longint'(a) * longint'(b);
        return x;
    endfunction

    // Caller is positioned at a negedge. Returns product and accept-to-done-sample edge count.
    task automatic run_op(input bit w8, input bit sm, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] p, output int lat);
        int  k;
        bit  seen;
        if (w8) begin start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin start32 = 1'b1; sm32 = sm; a32 = a; b32 = b; end
        @(posedge clkSys);
        @(negedge clkSys);
        // Inputs change after accept; the operation must not see them.
        if (w8) begin start8 = 1'b0; sm8 = ~sm; a8 = 8'($urandom); b8 = 8'($urandom); end
        else    begin start32 = 1'b0; sm32 = ~sm; a32 = $urandom; b32 = $urandom; end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clkSys);
            k++;
            @(negedge clkSys);
            seen = w8 ? done8 : done32;
        end
        check_eq("done_seen", {63'd0, seen}, 64'd1);
        check_eq("busy_with_done", {63'd0, (w8 ? busy8 : busy32)}, 64'd0);
        lat = k + 1;
        p = w8 ? {48'd0, prod8} : prod32;
    endtask

    logic [63:0] p;
    int          lat;
    int          cnt;
    logic [31:0] ra, rb;
    logic [31:0] dir_a [4] = '{32'd1, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] dir_b [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    bit          dir_s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] dir_p [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd49,
                               64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001};
    logic [7:0]  corner8 [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    initial begin
        // Reset held for five cycles.
        repeat (5) @(posedge clkSys);
        @(negedge clkSys);
        check_eq("rst_busy32", {63'd0, busy32}, 64'd0);
        check_eq("rst_done32", {63'd0, done32}, 64'd0);
        check_eq("rst_prod32", prod32, 64'd0);
        check_eq("rst_busy8", {63'd0, busy8}, 64'd0);
        check_eq("rst_done8", {63'd0, done8}, 64'd0);
        check_eq("rst_prod8", {48'd0, prod8}, 64'd0);
        rst_n = 1'b1;
        @(negedge clkSys);

        // Directed 32-bit values with latency, one-cycle done and hold checks.
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, dir_s[i], dir_a[i], dir_b[i], p, lat);
            check_eq("dir32_prod", p, dir_p[i]);
            check_eq("dir32_latency", 64'(lat), 64'd18);
            @(negedge clkSys);
            check_eq("done_one_cycle", {63'd0, done32}, 64'd0);
            repeat (2) @(negedge clkSys);
            check_eq("prod_hold", prod32, dir_p[i]);
        end

        // start during CALC with new operands is ignored.
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'd100; b32 = 32'd200;
        @(posedge clkSys);
        @(negedge clkSys);
        start32 = 1'b0;
        repeat (3) @(negedge clkSys);
        start32 = 1'b1; a32 = 32'd5; b32 = 32'd6;
        @(negedge clkSys);
        start32 = 1'b0;
        cnt = 0;
        while (!done32 && cnt < 100) begin @(negedge clkSys); cnt++; end
        check_eq("ignore_done", {63'd0, done32}, 64'd1);
        check_eq("ignore_prod", prod32, 64'd20000);
        @(negedge clkSys);

        // Back-to-back with start held through DONE.
        start32 = 1'b1; sm32 = 1'b1; a32 = 32'd3; b32 = 32'hFFFF_FFFC;
        @(posedge clkSys);
        cnt = 0;
        do begin @(negedge clkSys); cnt++; end while (!done32 && cnt < 100);
        check_eq("b2b_first", prod32, 64'hFFFF_FFFF_FFFF_FFF4);
        a32 = 32'hFFFF_FFF7; b32 = 32'd11;
        @(negedge clkSys);
        check_eq("b2b_busy", {63'd0, busy32}, 64'd1);
        check_eq("b2b_done_low", {63'd0, done32}, 64'd0);
        start32 = 1'b0;
        cnt = 0;
        while (!done32 && cnt < 100) begin @(negedge clkSys); cnt++; end
        check_eq("b2b_second", prod32, 64'hFFFF_FFFF_FFFF_FF9D);
        @(negedge clkSys);
        check_eq("b2b_done_pulse", {63'd0, done32}, 64'd0);

        // Asynchronous reset in the middle of CALC.
        start32 = 1'b1; sm32 = 1'b0; a32 = 32'd12345; b32 = 32'd678;
        @(posedge clkSys);
        @(negedge clkSys);
        start32 = 1'b0;
        repeat (4) @(negedge clkSys);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy32}, 64'd0);
        check_eq("abort_done", {63'd0, done32}, 64'd0);
        check_eq("abort_prod", prod32, 64'd0);
        repeat (3) @(negedge clkSys);
        rst_n = 1'b1;
        cnt = 0;
        repeat (25) begin
            @(negedge clkSys);
            if (done32) cnt++;
        end
        check_eq("abort_no_done", 64'(cnt), 64'd0);
        run_op(1'b0, 1'b0, 32'd12345, 32'd678, p, lat);
        check_eq("after_abort", p, 64'd8369910);

        // Random 32-bit operations, both modes.
        for (int i = 0; i < 300; i++) begin
            ra = $urandom; rb = $urandom;
            run_op(1'b0, i[0], ra, rb, p, lat);
            check_eq("rand32", p, ref_mul(1'b0, i[0], ra, rb));
            check_eq("rand32_latency", 64'(lat), 64'd18);
        end

        // 8-bit corners in both modes.
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                    run_op(1'b1, m[0], {24'd0, corner8[i]}, {24'd0, corner8[j]}, p, lat);
                    check_eq("corner8", p, ref_mul(1'b1, m[0], {24'd0, corner8[i]}, {24'd0, corner8[j]}));
                    check_eq("corner8_latency", 64'(lat), 64'd6);
                end

        // Random 8-bit operations, both modes.
        for (int i = 0; i < 1200; i++) begin
            ra = {24'd0, 8'($urandom)}; rb = {24'd0, 8'($urandom)};
            run_op(1'b1, i[0], ra, rb, p, lat);
            check_eq("rand8", p, ref_mul(1'b1, i[0], ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
